// File: rtl/regfile_wb.sv
// rtl/regfile_wb.sv - writeback sequencer driving register-file write and PC-branch ports
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream result handshake (in_ready = !full && !rst)
//   in_op/in_rd/in_data      op code, destination register, result/load word/branch offset
//   in_boff/in_link          LDRB byte offset, BL return address
//   we/wd/wa                 registered register-file write strobe, data, address
//   ib/bv                    registered branch strobe and PC offset
//   squashing                wrong-path squash counter is nonzero
//   err                      one-cycle pulse on an illegal retire
//   retire_cnt               wrapping count of retired (non-squashed, non-NOP, legal) entries
module regfile_wb #(
  parameter int WORD       = 4,
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2,
  parameter int SQUASH     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  in_op,
  input  logic [ADDR_WIDTH-1:0]       in_rd,
  input  logic [WORD*WIDTH-1:0]       in_data,
  input  logic [1:0]                  in_boff,
  input  logic [WORD*WIDTH-1:0]       in_link,
  output logic                        we,
  output logic [WORD*WIDTH-1:0]       wd,
  output logic [ADDR_WIDTH-1:0]       wa,
  output logic                        ib,
  output logic [WORD*WIDTH-1:0]       bv,
  output logic                        squashing,
  output logic                        err,
  output logic [31:0]                 retire_cnt
);

  localparam int D  = WORD * WIDTH;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(SQUASH + 2);

  localparam logic [PW:0]           CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = '1;
  localparam logic [ADDR_WIDTH-1:0] LR_ADDR  = ADDR_WIDTH'((1 << ADDR_WIDTH) - 2);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ALU  = 3'd1;
  localparam logic [2:0] OP_LDR  = 3'd2;
  localparam logic [2:0] OP_LDRB = 3'd3;
  localparam logic [2:0] OP_B    = 3'd4;
  localparam logic [2:0] OP_BL   = 3'd5;

  // FIFO storage (no reset needed: validity is tracked by count_q)
  logic [2:0]            op_mem_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_mem_q   [DEPTH];
  logic [D-1:0]          data_mem_q [DEPTH];
  logic [1:0]            boff_mem_q [DEPTH];
  logic [D-1:0]          link_mem_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [SW-1:0] sq_q, sq_d;
  logic          we_q, we_d, ib_q, ib_d, err_q, err_d;
  logic [D-1:0]  wd_q, wd_d, bv_q, bv_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [31:0]   cnt_q, cnt_d;

  logic push, pop, full;
  logic [2:0]            head_op;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic [D-1:0]          head_data, head_link;
  logic [1:0]            head_boff;
  logic [WIDTH-1:0]      byte_sel;

  assign full     = (count_q == CNT_FULL);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  // Pop decision uses occupancy before this edge's push, so a new entry waits one edge.
  assign pop      = (count_q != '0);

  assign head_op   = op_mem_q[rd_ptr_q];
  assign head_rd   = rd_mem_q[rd_ptr_q];
  assign head_data = data_mem_q[rd_ptr_q];
  assign head_boff = boff_mem_q[rd_ptr_q];
  assign head_link = link_mem_q[rd_ptr_q];

  always_comb begin
    byte_sel = '0;
    for (int b = 0; b < WORD; b++) begin
      if (int'(head_boff) == b) byte_sel = head_data[b*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);

    we_d  = 1'b0;
    ib_d  = 1'b0;
    err_d = 1'b0;
    wd_d  = wd_q;
    wa_d  = wa_q;
    bv_d  = bv_q;
    sq_d  = sq_q;
    cnt_d = cnt_q;

    if (pop) begin
      if (sq_q != '0) begin
        // Wrong-path entry: discard silently, even branches.
        sq_d = sq_q - SW'(1);
      end else begin
        case (head_op)
          OP_NOP: ;
          OP_ALU, OP_LDR, OP_LDRB: begin
            if (head_rd == PC_ADDR) begin
              // PC may only change through the branch port.
              err_d = 1'b1;
            end else begin
              we_d  = 1'b1;
              wa_d  = head_rd;
              wd_d  = (head_op == OP_LDRB) ? D'(byte_sel) : head_data;
              cnt_d = cnt_q + 32'd1;
            end
          end
          OP_B, OP_BL: begin
            ib_d  = 1'b1;
            bv_d  = head_data;
            sq_d  = SW'(SQUASH);
            cnt_d = cnt_q + 32'd1;
            if (head_op == OP_BL) begin
              we_d = 1'b1;
              wa_d = LR_ADDR;
              wd_d = head_link;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sq_q     <= '0;
      we_q     <= 1'b0;
      ib_q     <= 1'b0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      wa_q     <= '0;
      bv_q     <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sq_q     <= sq_d;
      we_q     <= we_d;
      ib_q     <= ib_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      wa_q     <= wa_d;
      bv_q     <= bv_d;
      cnt_q    <= cnt_d;
      if (push) begin
        op_mem_q[wr_ptr_q]   <= in_op;
        rd_mem_q[wr_ptr_q]   <= in_rd;
        data_mem_q[wr_ptr_q] <= in_data;
        boff_mem_q[wr_ptr_q] <= in_boff;
        link_mem_q[wr_ptr_q] <= in_link;
      end
    end
  end

  assign we         = we_q;
  assign wd         = wd_q;
  assign wa         = wa_q;
  assign ib         = ib_q;
  assign bv         = bv_q;
  assign err        = err_q;
  assign squashing  = (sq_q != '0);
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb.sv
// tb/tb_regfile_wb.sv - randomized and directed bench for regfile_wb against a queue model
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [3:0]  in_rd;
  logic [31:0] in_data;
  logic [1:0]  in_boff;
  logic [31:0] in_link;
  logic        we, ib, squashing, err;
  logic [31:0] wd, bv, retire_cnt;
  logic [3:0]  wa;

  regfile_wb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_data(in_data),
    .in_boff(in_boff), .in_link(in_link),
    .we(we), .wd(wd), .wa(wa), .ib(ib), .bv(bv),
    .squashing(squashing), .err(err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [1:0]  boff;
    logic [31:0] link;
  } ent_t;

  ent_t q[$];
  int   m_sq;
  logic m_we, m_ib, m_err;
  logic [31:0] m_wd, m_bv, m_cnt;
  logic [3:0]  m_wa;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one retire per edge from the head of a queue of at most 2 entries.
  task automatic model_edge();
    ent_t e;
    bit   was_full;
    if (rst) begin
      q.delete();
      m_sq = 0; m_cnt = 0;
      m_we = 0; m_ib = 0; m_err = 0;
      m_wd = 0; m_wa = 0; m_bv = 0;
      return;
    end
    was_full = (q.size() == 2);
    m_we = 0; m_ib = 0; m_err = 0;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (m_sq > 0) begin
        m_sq = m_sq - 1;
      end else if (e.op == 1 || e.op == 2 || e.op == 3) begin
        if (e.rd == 4'd15) m_err = 1;
        else begin
          m_we = 1;
          m_wa = e.rd;
          m_wd = (e.op == 3) ? ((e.data >> (8 * e.boff)) & 32'hFF) : e.data;
          m_cnt = m_cnt + 1;
        end
      end else if (e.op == 4 || e.op == 5) begin
        m_ib = 1; m_bv = e.data; m_sq = 2; m_cnt = m_cnt + 1;
        if (e.op == 5) begin
          m_we = 1; m_wa = 4'd14; m_wd = e.link;
        end
      end else if (e.op >= 6) begin
        m_err = 1;
      end
    end
    if (in_valid && !was_full) begin
      e.op = in_op; e.rd = in_rd; e.data = in_data; e.boff = in_boff; e.link = in_link;
      q.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [2:0] op,
                      input logic [3:0] rd, input logic [31:0] data,
                      input logic [1:0] boff, input logic [31:0] link);
    rst = r; in_valid = v; in_op = op; in_rd = rd;
    in_data = data; in_boff = boff; in_link = link;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q.size() < 2)});
    @(posedge clk);
    model_edge();
    #1;
    chk("we", {31'd0, we}, {31'd0, m_we});
    chk("wa", {28'd0, wa}, {28'd0, m_wa});
    chk("wd", wd, m_wd);
    chk("ib", {31'd0, ib}, {31'd0, m_ib});
    chk("bv", bv, m_bv);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("squashing", {31'd0, squashing}, {31'd0, (m_sq > 0)});
    chk("retire_cnt", retire_cnt, m_cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_op = 0; in_rd = 0; in_data = 0; in_boff = 0; in_link = 0;
    m_sq = 0; m_cnt = 0; m_we = 0; m_ib = 0; m_err = 0; m_wd = 0; m_wa = 0; m_bv = 0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 3, 32'hDEAD, 0, 0);
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_cnt", retire_cnt, 32'd0);

    // ALU rd=3
    step(0, 1, 1, 3, 32'h12345678, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("plan_alu_we", {31'd0, we}, 32'd1);
    chk("plan_alu_wd", wd, 32'h12345678);
    idle(1);
    chk("plan_alu_we_off", {31'd0, we}, 32'd0);
    chk("plan_alu_cnt", retire_cnt, 32'd1);

    // LDRB byte extraction
    step(0, 1, 3, 2, 32'hAABBCCDD, 1, 0);
    step(0, 1, 3, 2, 32'hAABBCCDD, 3, 0);
    chk("plan_ldrb1", wd, 32'h000000CC);
    idle(1);
    chk("plan_ldrb3", wd, 32'h000000AA);
    idle(1);

    // BL then two squashed ALUs, then one that writes
    step(0, 1, 5, 0, 32'h10, 0, 32'h104);
    step(0, 1, 1, 1, 32'h11, 0, 0);
    chk("plan_bl_wa", {28'd0, wa}, 32'd14);
    chk("plan_bl_wd", wd, 32'h104);
    step(0, 1, 1, 4, 32'h44, 0, 0);
    step(0, 1, 1, 5, 32'h55, 0, 0);
    idle(2);
    chk("plan_bl_rd5", {28'd0, wa}, 32'd5);
    chk("plan_bl_cnt", retire_cnt, 32'd5);

    // Write to PC and reserved op
    step(0, 1, 1, 15, 32'h1, 0, 0);
    step(0, 1, 7, 2, 32'h2, 0, 0);
    chk("plan_pc_err", {31'd0, err}, 32'd1);
    idle(1);
    chk("plan_rsv_err", {31'd0, err}, 32'd1);
    idle(1);

    // Back-to-back stream with reset in the middle
    for (int i = 0; i < 4; i++) step(0, 1, 1, 4'(i + 6), 32'(i), 0, 0);
    step(1, 1, 1, 9, 32'h99, 0, 0);
    idle(3);
    chk("plan_rst_cnt", retire_cnt, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom,
           2'($urandom_range(0, 3)), $urandom);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
